// File: rtl/det_pkg.sv
// Shared types and constants for the determinant engine front-end.
package det_pkg;

    localparam int N_DIM    = 8;
    localparam int ELEM_W   = 32;
    localparam int ELEM_CNT = N_DIM * N_DIM;
    localparam int ADDR_W   = $clog2(ELEM_CNT);

    typedef logic signed [ELEM_W-1:0] det_t;

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_LOAD   = 5'b00010,
        S_START  = 5'b00100,
        S_WAIT   = 5'b01000,
        S_RESULT = 5'b10000
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer moves only when a job ends.
module rr_arb2 (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] Req,
    input  logic       Release,
    input  logic       Abort,
    input  logic       Owner,
    output logic       Any,
    output logic       Pick
);

    logic ptr;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            ptr <= 1'b0;
        else if (Release)
            ptr <= ~Owner;
        else if (Abort)
            ptr <= ~ptr;
    end

    assign Any  = |Req;
    assign Pick = Req[ptr] ? ptr : ~ptr;

endmodule

// File: rtl/det_engine_sched.sv
// Shares one determinant engine between two requesters: arbitrate, stream the
// 8x8 matrix into the engine buffer, run the engine under a watchdog, return the result.
module det_engine_sched
    import det_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [1:0]        Req,
    output logic [1:0]        Grant,
    input  logic              Wr_Valid,
    input  det_t              Wr_Data,
    output logic              Wr_Ready,
    output logic              Buf_We,
    output logic [ADDR_W-1:0] Buf_Addr,
    output det_t              Buf_Data,
    output logic              Eng_Start,
    input  logic              Eng_Done,
    input  det_t              Eng_Det,
    output logic              Eng_Ack,
    output logic              Eng_Rst,
    output logic              Res_Valid,
    output det_t              Res_Det,
    output logic              Res_Id,
    output logic              Res_Err,
    input  logic              Res_Ack,
    output logic              q_Idle,
    output logic              q_Load,
    output logic              q_Start,
    output logic              q_Wait,
    output logic              q_Result
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ELEM_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ELEM_CNT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [TMO_W-1:0] tmo;
    logic             arb_any;
    logic             arb_pick;
    logic             job_abort;
    logic             job_release;

    assign q_Idle   = (state == S_IDLE);
    assign q_Load   = (state == S_LOAD);
    assign q_Start  = (state == S_START);
    assign q_Wait   = (state == S_WAIT);
    assign q_Result = (state == S_RESULT);

    // The owner withdrawing its request ends the load immediately, so stop accepting too.
    assign Wr_Ready    = q_Load && Req[Res_Id];
    assign job_abort   = q_Load && !Req[Res_Id];
    assign job_release = q_Result && Res_Ack;

    rr_arb2 u_arb (
        .Clk     (Clk),
        .Reset   (Reset),
        .Req     (Req),
        .Release (job_release),
        .Abort   (job_abort),
        .Owner   (Res_Id),
        .Any     (arb_any),
        .Pick    (arb_pick)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tmo       <= '0;
            Grant     <= 2'b00;
            Buf_We    <= 1'b0;
            Buf_Addr  <= '0;
            Buf_Data  <= '0;
            Eng_Start <= 1'b0;
            Eng_Ack   <= 1'b0;
            Eng_Rst   <= 1'b0;
            Res_Valid <= 1'b0;
            Res_Det   <= '0;
            Res_Id    <= 1'b0;
            Res_Err   <= 1'b0;
        end else begin
            Buf_We    <= 1'b0;
            Eng_Start <= 1'b0;
            Eng_Ack   <= 1'b0;
            Eng_Rst   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (arb_any) begin
                        Grant  <= arb_pick ? 2'b10 : 2'b01;
                        Res_Id <= arb_pick;
                        cnt    <= '0;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (job_abort) begin
                        Grant <= 2'b00;
                        state <= S_IDLE;
                    end else if (Wr_Valid) begin
                        Buf_We   <= 1'b1;
                        Buf_Addr <= cnt[ADDR_W-1:0];
                        Buf_Data <= Wr_Data;
                        cnt      <= (cnt == CNT_FULL) ? cnt : cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            Eng_Start <= 1'b1;
                            tmo       <= '0;
                            state     <= S_START;
                        end
                    end
                end
                S_START: begin
                    tmo   <= tmo + TMO_W'(1);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (Eng_Done) begin
                        Res_Det   <= Eng_Det;
                        Res_Err   <= 1'b0;
                        Eng_Ack   <= 1'b1;
                        Res_Valid <= 1'b1;
                        state     <= S_RESULT;
                    end else if (tmo == TMO_LAST) begin
                        Res_Det   <= '0;
                        Res_Err   <= 1'b1;
                        Eng_Rst   <= 1'b1;
                        Res_Valid <= 1'b1;
                        state     <= S_RESULT;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                S_RESULT: begin
                    if (Res_Ack) begin
                        Res_Valid <= 1'b0;
                        Grant     <= 2'b00;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_det_engine_sched.sv
// Directed bench for det_engine_sched: load, arbitration, abort, watchdog and reset cases.
module tb_det_engine_sched;
    import det_pkg::*;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic [1:0]        Req = 2'b00;
    logic [1:0]        Grant;
    logic              Wr_Valid = 1'b0;
    det_t              Wr_Data = '0;
    logic              Wr_Ready;
    logic              Buf_We;
    logic [ADDR_W-1:0] Buf_Addr;
    det_t              Buf_Data;
    logic              Eng_Start;
    logic              Eng_Done = 1'b0;
    det_t              Eng_Det = '0;
    logic              Eng_Ack;
    logic              Eng_Rst;
    logic              Res_Valid;
    det_t              Res_Det;
    logic              Res_Id;
    logic              Res_Err;
    logic              Res_Ack = 1'b0;
    logic              q_Idle, q_Load, q_Start, q_Wait, q_Result;

    det_engine_sched #(.TIMEOUT_CYC(16)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Grant(Grant),
        .Wr_Valid(Wr_Valid), .Wr_Data(Wr_Data), .Wr_Ready(Wr_Ready),
        .Buf_We(Buf_We), .Buf_Addr(Buf_Addr), .Buf_Data(Buf_Data),
        .Eng_Start(Eng_Start), .Eng_Done(Eng_Done), .Eng_Det(Eng_Det),
        .Eng_Ack(Eng_Ack), .Eng_Rst(Eng_Rst),
        .Res_Valid(Res_Valid), .Res_Det(Res_Det), .Res_Id(Res_Id),
        .Res_Err(Res_Err), .Res_Ack(Res_Ack),
        .q_Idle(q_Idle), .q_Load(q_Load), .q_Start(q_Start),
        .q_Wait(q_Wait), .q_Result(q_Result)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Event log, sampled shortly after each rising edge.
    int          cyc = 0, wr_n = 0, start_n = 0, ack_n = 0, rst_n_cnt = 0, rv_n = 0;
    int          start_cyc = 0, start_wr = 0, rst_cyc = 0, gnt_bad = 0, we_bad = 0;
    logic        rv_q = 1'b0;
    logic [31:0] wr_addr [512];
    logic [31:0] wr_data [512];

    always @(posedge Clk) begin
        #2;
        cyc++;
        if (Buf_We) begin
            if (wr_n < 512) begin
                wr_addr[wr_n] = 32'(Buf_Addr);
                wr_data[wr_n] = Buf_Data;
            end
            wr_n++;
            if (!(q_Load || q_Start)) we_bad++;
        end
        if (Eng_Start) begin
            start_n++;
            start_cyc = cyc;
            start_wr  = wr_n;
        end
        if (Eng_Ack) ack_n++;
        if (Eng_Rst) begin
            rst_n_cnt++;
            rst_cyc = cyc;
        end
        if (Res_Valid && !rv_q) rv_n++;
        rv_q = Res_Valid;
        if (Grant == 2'b11) gnt_bad++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Req = 2'b00; Wr_Valid = 1'b0; Eng_Done = 1'b0; Res_Ack = 1'b0;
        repeat (2) step();
        Reset = 1'b0;
        step();
    endtask

    task automatic load(input int base, input int n, input bit toggle);
        int  k = 0;
        int  c = 0;
        bit  acc;
        while (k < n && c < 400) begin
            step();
            Wr_Valid = toggle ? (c % 2 == 0) : 1'b1;
            Wr_Data  = base + k;
            #1 acc = Wr_Valid && Wr_Ready;
            if (acc) k++;
            c++;
        end
        step();
        Wr_Valid = 1'b0;
        check("accepts", k, n);
    endtask

    task automatic check_writes(input int w0, input int n, input int base);
        check("wr_count", wr_n - w0, n);
        for (int i = 0; i < n; i++) begin
            check("wr_addr", wr_addr[w0 + i], i);
            check("wr_data", wr_data[w0 + i], base + i);
        end
    endtask

    task automatic wait_start(input int s0);
        int b = 0;
        while (start_n == s0 && b < 200) begin
            step();
            b++;
        end
        check("eng_start", start_n - s0, 1);
    endtask

    task automatic finish_job(input int det, input logic id);
        int b = 0;
        Eng_Det  = det;
        Eng_Done = 1'b1;
        while (!Res_Valid && b < 50) begin
            step();
            b++;
        end
        Eng_Done = 1'b0;
        check("res_valid", Res_Valid, 1);
        check("res_det", Res_Det, det);
        check("res_id", Res_Id, id);
        check("res_err", Res_Err, 0);
    endtask

    task automatic do_ack();
        Res_Ack = 1'b1;
        step();
        Res_Ack = 1'b0;
        check("ack_valid", Res_Valid, 0);
        check("ack_grant", Grant, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w0, s0, a0, r0, v0, b;

        // Reset state
        do_reset();
        check("rst_grant", Grant, 0);
        check("rst_valid", Res_Valid, 0);
        check("rst_ready", Wr_Ready, 0);
        check("rst_buf_we", Buf_We, 0);
        check("rst_start", Eng_Start, 0);
        check("rst_det", Res_Det, 0);
        check("rst_idle", q_Idle, 1);
        check("rst_load", q_Load, 0);

        // Single requester, full streaming load, engine returns -306
        w0 = wr_n; s0 = start_n; a0 = ack_n;
        Req = 2'b01;
        load(1, 64, 1'b0);
        check_writes(w0, 64, 1);
        wait_start(s0);
        finish_job(-306, 1'b0);
        check("eng_ack", ack_n - a0, 1);
        Req = 2'b00;
        do_ack();

        // Wr_Valid toggling: exactly 64 writes, START only after the last accept
        w0 = wr_n; s0 = start_n;
        Req = 2'b01;
        load(200, 64, 1'b1);
        check_writes(w0, 64, 200);
        wait_start(s0);
        check("start_after_64", start_wr - w0, 64);
        finish_job(32'h1234_5678, 1'b0);
        Req = 2'b00;
        do_ack();

        // Both requesting from reset: 0, then 1, then 0
        do_reset();
        Req = 2'b11;
        step();
        check("rr_first", Grant, 2'b01);
        s0 = start_n;
        load(300, 64, 1'b0);
        wait_start(s0);
        finish_job(7, 1'b0);
        do_ack();
        step();
        check("rr_second", Grant, 2'b10);
        s0 = start_n;
        load(400, 64, 1'b0);
        wait_start(s0);
        finish_job(-1, 1'b1);
        do_ack();
        step();
        check("rr_third", Grant, 2'b01);

        // Owner drops Req after 10 elements: abort, pointer flips
        do_reset();
        w0 = wr_n; s0 = start_n; v0 = rv_n;
        Req = 2'b01;
        load(500, 10, 1'b0);
        Req = 2'b00;
        step();
        check("abort_grant", Grant, 0);
        check("abort_idle", q_Idle, 1);
        repeat (6) step();
        check("abort_writes", wr_n - w0, 10);
        check("abort_no_start", start_n - s0, 0);
        check("abort_no_result", rv_n - v0, 0);
        Req = 2'b11;
        step();
        check("abort_ptr_flip", Grant, 2'b10);
        Req = 2'b00;
        repeat (2) step();

        // Watchdog: no done, Eng_Rst 16 cycles after Eng_Start
        s0 = start_n; r0 = rst_n_cnt; a0 = ack_n;
        Req = 2'b01;
        load(600, 64, 1'b0);
        wait_start(s0);
        b = 0;
        while (rst_n_cnt == r0 && b < 100) begin
            step();
            b++;
        end
        check("tmo_rst_pulse", rst_n_cnt - r0, 1);
        check("tmo_delay", rst_cyc - start_cyc, 16);
        check("tmo_valid", Res_Valid, 1);
        check("tmo_err", Res_Err, 1);
        check("tmo_det", Res_Det, 0);
        check("tmo_no_ack", ack_n - a0, 0);
        step();
        check("tmo_rst_once", rst_n_cnt - r0, 1);
        Req = 2'b00;
        do_ack();

        // Reset during WAIT discards the job
        s0 = start_n;
        Req = 2'b01;
        load(700, 64, 1'b0);
        wait_start(s0);
        repeat (3) step();
        check("pre_rst_wait", q_Wait, 1);
        Reset = 1'b1;
        #1;
        check("wrst_grant", Grant, 0);
        check("wrst_idle", q_Idle, 1);
        check("wrst_wait", q_Wait, 0);
        check("wrst_valid", Res_Valid, 0);
        check("wrst_start", Eng_Start, 0);
        step();
        Reset = 1'b0;
        Req = 2'b00;
        v0 = rv_n; a0 = ack_n;
        Eng_Done = 1'b1;
        repeat (5) step();
        Eng_Done = 1'b0;
        check("wrst_no_result", rv_n - v0, 0);
        check("wrst_no_ack", ack_n - a0, 0);
        check("wrst_valid_low", Res_Valid, 0);

        check("grant_onehot", gnt_bad, 0);
        check("buf_we_window", we_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
